vote_input_arbiter: RTL and testbench
=====================================

VOTE_INPUT_ARBITER -- requirements
Module: vote_input_arbiter

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 10, consecutive stable cycles needed to qualify a press or a release (legal range 2..255).
REQ-002 Parameter: LOCKOUT_CYCLES, default 100, dead time after release before the next vote is accepted (legal range 1..65535).
REQ-003 The module SHALL use one clock, and its reset SHALL be asynchronous and active-low, with ports as follows:
- clock  input  1  system clock; all flops rising-edge.
- reset  input  1  asynchronous reset, asserted low.
- mode  input  1  0 = voting, 1 = result display; votes are suppressed while high.
- button  input  4  raw, asynchronous candidate buttons; bit i = candidate i+1.
- valid_vote  output  4  one-hot, single-cycle accepted-vote pulse; drives the vote logger and mode control.
- reject_pulse  output  1  single-cycle pulse when a multi-button press is rejected.
- busy  output  1  high whenever the FSM is not in IDLE.
- accepted_count  output  8  total accepted votes, saturating.

Function
REQ-004 The design SHALL pass button through a 2-flop synchronizer; the FSM SHALL see only the synchronized vector (sb).
REQ-005 The FSM SHALL have exactly five states: IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE and LOCKOUT.
REQ-006 IDLE: when mode=0 and sb!=0, the FSM SHALL capture sb into the pattern register, clear the counter and go to DEBOUNCE; when mode=1, it SHALL stay in IDLE regardless of sb.
REQ-007 DEBOUNCE: if sb differs from the captured pattern, the FSM SHALL return to IDLE with no output; if mode=1, it SHALL go to WAIT_RELEASE with no output.
REQ-008 DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES-1 with sb equal to the pattern, the FSM SHALL go to ACCEPT if the pattern is one-hot, otherwise assert reject_pulse for one cycle and go to WAIT_RELEASE.
REQ-009 ACCEPT: the FSM SHALL last exactly one cycle, drive valid_vote = pattern AND NOT mode (registered), and then go to WAIT_RELEASE.
REQ-010 In ACCEPT with mode=0, accepted_count SHALL increment by 1 and SHALL hold at 255 (no wrap).
REQ-011 WAIT_RELEASE: the FSM SHALL go to LOCKOUT only after sb==0 for DEBOUNCE_CYCLES consecutive cycles; any nonzero sb SHALL restart this count.
REQ-012 LOCKOUT: the FSM SHALL ignore all buttons for LOCKOUT_CYCLES cycles and then go to IDLE.
REQ-013 With button stable one-hot from clock edge 0 and mode=0, valid_vote SHALL be high for exactly the cycle following edge DEBOUNCE_CYCLES+2.
REQ-014 valid_vote SHALL never have more than one bit set, and SHALL be zero in every state except ACCEPT.
REQ-015 Holding a button down SHALL produce exactly one valid_vote pulse; a new vote SHALL require release, lockout and a fresh press.
REQ-016 A press arriving during WAIT_RELEASE or LOCKOUT SHALL produce no pulse and SHALL NOT be queued.
REQ-017 Counter widths SHALL be sized from the parameters, and no counter SHALL wrap inside a state.

Reset
REQ-018 When reset is low: state=IDLE, synchronizer=0, pattern=0, counters=0, valid_vote=4'b0000, reject_pulse=0, busy=0, accepted_count=8'd0.
REQ-019 Reset asserted mid-operation (including during ACCEPT) SHALL clear the outputs immediately, and no pulse SHALL be issued after release.
REQ-020 After reset deasserts, the FSM SHALL start in IDLE, and a button already held SHALL be treated as a fresh press.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
REQ-021 button=4'b0010 held for 40 cycles, mode=0 -> valid_vote=4'b0010 for exactly one cycle after edge 6, accepted_count=1, busy high until release+4+8 cycles.
REQ-022 button=4'b0101 held for 20 cycles -> reject_pulse once, valid_vote stays 0, accepted_count=0.
REQ-023 button=4'b0001 glitch for 2 cycles, then low -> no pulse, FSM back in IDLE, busy low.
REQ-024 mode=1 with button=4'b1000 held for 30 cycles -> no pulse, accepted_count=0; mode raised during DEBOUNCE -> no pulse.
REQ-025 300 clean presses separated by release and lockout -> accepted_count=255 (saturated), 300 valid_vote pulses observed.
REQ-026 reset pulsed low in the ACCEPT cycle -> valid_vote=0 in that cycle and afterwards, accepted_count=0, state=IDLE.

Source files
------------

// File: rtl/vote_input_arbiter.sv
// Debounced, one-hot-qualified vote capture for four candidate buttons.
// Accepts one vote per press, then requires release and a lockout period.
module vote_input_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 10,
    parameter int unsigned LOCKOUT_CYCLES  = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic [3:0] button,
    output logic [3:0] valid_vote,
    output logic       reject_pulse,
    output logic       busy,
    output logic [7:0] accepted_count
);

    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        ACCEPT,
        WAIT_RELEASE,
        LOCKOUT
    } state_t;

    state_t             state, state_next;
    logic [3:0]         sync_meta, sb;
    logic [3:0]         pattern, pattern_next;
    logic [DEB_W-1:0]   deb_cnt, deb_cnt_next;
    logic [LOCK_W-1:0]  lock_cnt, lock_cnt_next;
    logic [3:0]         vote_next;
    logic               reject_next;
    logic [7:0]         count_next;
    logic               pattern_one_hot;

    assign pattern_one_hot = (pattern != '0) && ((pattern & (pattern - 4'd1)) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta      <= '0;
            sb             <= '0;
            state          <= IDLE;
            pattern        <= '0;
            deb_cnt        <= '0;
            lock_cnt       <= '0;
            valid_vote     <= '0;
            reject_pulse   <= 1'b0;
            accepted_count <= '0;
        end else begin
            sync_meta      <= button;
            sb             <= sync_meta;
            state          <= state_next;
            pattern        <= pattern_next;
            deb_cnt        <= deb_cnt_next;
            lock_cnt       <= lock_cnt_next;
            valid_vote     <= vote_next;
            reject_pulse   <= reject_next;
            accepted_count <= count_next;
        end
    end

    always_comb begin
        state_next    = state;
        pattern_next  = pattern;
        deb_cnt_next  = deb_cnt;
        lock_cnt_next = lock_cnt;
        vote_next     = '0;
        reject_next   = 1'b0;
        count_next    = accepted_count;
        busy          = (state != IDLE);

        case (state)
            IDLE: begin
                if (!mode && (sb != '0)) begin
                    pattern_next = sb;
                    deb_cnt_next = '0;
                    state_next   = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (sb != pattern) begin
                    state_next = IDLE;
                end else if (mode) begin
                    deb_cnt_next = '0;
                    state_next   = WAIT_RELEASE;
                end else if (deb_cnt == DEB_LAST) begin
                    // Outputs are registered on entry so the pulse coincides with ACCEPT.
                    if (pattern_one_hot) begin
                        vote_next  = pattern & {4{~mode}};
                        state_next = ACCEPT;
                        if (accepted_count != '1) begin
                            count_next = accepted_count + 8'd1;
                        end
                    end else begin
                        reject_next  = 1'b1;
                        deb_cnt_next = '0;
                        state_next   = WAIT_RELEASE;
                    end
                end else begin
                    deb_cnt_next = deb_cnt + DEB_W'(1);
                end
            end

            ACCEPT: begin
                deb_cnt_next = '0;
                state_next   = WAIT_RELEASE;
            end

            WAIT_RELEASE: begin
                if (sb != '0) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    lock_cnt_next = '0;
                    state_next    = LOCKOUT;
                end else begin
                    deb_cnt_next = deb_cnt + DEB_W'(1);
                end
            end

            LOCKOUT: begin
                if (lock_cnt == LOCK_LAST) begin
                    state_next = IDLE;
                end else begin
                    lock_cnt_next = lock_cnt + LOCK_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    a_vote_one_hot: assert property (@(posedge clock) disable iff (!reset)
        $onehot0(valid_vote));

    a_vote_only_in_accept: assert property (@(posedge clock) disable iff (!reset)
        (valid_vote != '0) |-> (state == ACCEPT));

endmodule

// File: tb/tb_vote_input_arbiter.sv
// Scoreboard bench for vote_input_arbiter with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
module tb_vote_input_arbiter;

    localparam int unsigned DEB = 4;
    localparam int unsigned LOCK = 8;
    // Press applied before edge 0 pulses after edge DEB+2, seen at the following negedge.
    localparam int unsigned LAT = DEB + 3;

    typedef struct {
        logic [3:0]  vote;
        logic        rej;
        int unsigned at_edge;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic [3:0] button;
    logic [3:0] valid_vote;
    logic       reject_pulse;
    logic       busy;
    logic [7:0] accepted_count;

    int unsigned edges = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned votes_seen = 0;
    int unsigned exp_votes = 0;
    int unsigned exp_count = 0;
    exp_t        sb_q[$];

    vote_input_arbiter #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mode          (mode),
        .button        (button),
        .valid_vote    (valid_vote),
        .reject_pulse  (reject_pulse),
        .busy          (busy),
        .accepted_count(accepted_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edges <= edges + 1;

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic push_exp(input logic [3:0] vote, input logic rej);
        exp_t e;
        e.vote = vote;
        e.rej = rej;
        e.at_edge = edges + LAT;
        sb_q.push_back(e);
        if (vote != 4'b0000) begin
            exp_votes++;
            if (exp_count < 255) exp_count++;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            while (sb_q.size() > 0 && edges > sb_q[0].at_edge) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_pulse: nothing seen, expected vote %b reject %b at edge %0d",
                         sb_q[0].vote, sb_q[0].rej, sb_q[0].at_edge);
                void'(sb_q.pop_front());
            end
            if (valid_vote != 4'b0000 || reject_pulse) begin
                if (valid_vote != 4'b0000) votes_seen++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: got vote %b reject %b at edge %0d, expected none",
                             valid_vote, reject_pulse, edges);
                end else begin
                    e = sb_q.pop_front();
                    if (valid_vote !== e.vote || reject_pulse !== e.rej || edges != e.at_edge) begin
                        n_fail++;
                        $display("FAIL pulse: got vote %b reject %b at edge %0d, expected vote %b reject %b at edge %0d",
                                 valid_vote, reject_pulse, edges, e.vote, e.rej, e.at_edge);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        mode = 1'b0;
        button = 4'b0000;
        tick(3);
        check("reset_vote", {28'd0, valid_vote}, 0);
        check("reset_reject", {31'd0, reject_pulse}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_count", {24'd0, accepted_count}, 0);
        reset = 1'b1;
        tick(2);

        // single clean vote held 40 cycles
        button = 4'b0010;
        push_exp(4'b0010, 1'b0);
        tick(3);
        check("t021_busy_debounce", {31'd0, busy}, 1);
        tick(37);
        check("t021_count", {24'd0, accepted_count}, exp_count);
        check("t021_busy_held", {31'd0, busy}, 1);
        button = 4'b0000;
        tick(13);
        check("t021_busy_lockout_end", {31'd0, busy}, 1);
        tick(1);
        check("t021_busy_idle", {31'd0, busy}, 0);

        // multi-button press rejected
        button = 4'b0101;
        push_exp(4'b0000, 1'b1);
        tick(20);
        check("t022_count", {24'd0, accepted_count}, exp_count);
        button = 4'b0000;
        tick(16);
        check("t022_busy", {31'd0, busy}, 0);

        // two-cycle glitch
        button = 4'b0001;
        tick(2);
        button = 4'b0000;
        tick(1);
        check("t023_busy_debounce", {31'd0, busy}, 1);
        tick(2);
        check("t023_busy_idle", {31'd0, busy}, 0);

        // display mode suppresses votes
        mode = 1'b1;
        button = 4'b1000;
        tick(30);
        check("t024_busy_mode", {31'd0, busy}, 0);
        check("t024_count_mode", {24'd0, accepted_count}, exp_count);
        button = 4'b0000;
        mode = 1'b0;
        tick(3);
        button = 4'b1000;
        tick(3);
        check("t024_busy_debounce", {31'd0, busy}, 1);
        mode = 1'b1;
        tick(10);
        check("t024_busy_wait", {31'd0, busy}, 1);
        button = 4'b0000;
        mode = 1'b0;
        tick(20);
        check("t024_busy_idle", {31'd0, busy}, 0);
        check("t024_count", {24'd0, accepted_count}, exp_count);

        // press during lockout is dropped, not queued
        button = 4'b0001;
        push_exp(4'b0001, 1'b0);
        tick(10);
        button = 4'b0000;
        tick(7);
        check("t016_busy_lockout", {31'd0, busy}, 1);
        button = 4'b0100;
        tick(3);
        button = 4'b0000;
        tick(10);
        check("t016_busy_idle", {31'd0, busy}, 0);
        check("t016_count", {24'd0, accepted_count}, exp_count);

        // 300 clean presses saturate the counter
        for (int i = 0; i < 300; i++) begin
            button = 4'b0001 << (i % 4);
            push_exp(button, 1'b0);
            tick(10);
            button = 4'b0000;
            tick(15);
        end
        check("t025_count_sat", {24'd0, accepted_count}, 255);
        check("t025_votes_seen", votes_seen, exp_votes);

        // reset in the ACCEPT cycle, button still held afterwards
        button = 4'b0100;
        tick(6);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        exp_count = 0;
        check("t026_vote_cleared", {28'd0, valid_vote}, 0);
        check("t026_count_cleared", {24'd0, accepted_count}, exp_count);
        check("t026_busy_cleared", {31'd0, busy}, 0);
        tick(3);
        check("t026_vote_in_reset", {28'd0, valid_vote}, 0);
        reset = 1'b1;
        push_exp(4'b0100, 1'b0);
        tick(10);
        button = 4'b0000;
        tick(16);
        check("t026_count_fresh", {24'd0, accepted_count}, exp_count);
        check("t026_busy_idle", {31'd0, busy}, 0);

        tick(5);
        check("scoreboard_empty", sb_q.size(), 0);
        check("total_votes", votes_seen, exp_votes);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
